// File: rtl/fpm_share_arbiter_pkg.sv
// Shared definitions for the FP32 multiplier share arbiter: pipeline depth,
// the tag record carried beside the multiplier, and the drain FSM states.
package fpm_share_arbiter_pkg;

    localparam int unsigned FPM_LATENCY = 11;

    // Tag id is sized for the largest supported requester count (8).
    localparam int unsigned TAG_IDW = 3;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } fpm_tag_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } fpm_state_e;

endpackage

// File: rtl/fpm_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or above the
// pointer (with wrap), pointer advances to winner+1 on accept.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            accept
);

    logic [IDW-1:0]    ptr;
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [IDW:0]      sum;
    logic              found;

    assign req_dbl = {req, req};
    assign req_rot = NREQ'(req_dbl >> ptr);

    // Search the rotated vector so position 0 is the pointer, then map back.
    always_comb begin
        found    = 1'b0;
        sum      = '0;
        grant_id = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IDW+1)'(i);
                if (sum >= (IDW+1)'(NREQ)) begin
                    sum = sum - (IDW+1)'(NREQ);
                end
                grant_id = sum[IDW-1:0];
            end
        end
    end

    assign accept = en && found;
    assign grant  = accept ? (NREQ'(1) << grant_id) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

endmodule

// File: rtl/fpm_share_arbiter.sv
// Shares one pipelined FP32 multiplier between NREQ requesters: round-robin
// issue, id tag pipe aligned with the multiplier, and a drain sequence.
module fpm_share_arbiter
    import fpm_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LATENCY = FPM_LATENCY,
    parameter int unsigned IDW     = $clog2(NREQ),
    localparam int unsigned CW     = $clog2(LATENCY + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [31:0]       fpm_a,
    output logic [31:0]       fpm_b,
    input  logic [31:0]       fpm_sum,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_data,
    input  logic              drain_req,
    output logic              drain_done,
    output logic              busy,
    output logic [CW-1:0]     inflight
);

    fpm_state_e     state, state_nxt;
    logic           grant_en;
    logic           accept;
    logic [IDW-1:0] grant_id;
    logic           retire;
    logic [CW-1:0]  inflight_q;
    fpm_tag_t       new_tag;
    fpm_tag_t       tag_pipe [0:LATENCY];
    logic           tag_id_unused;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .en       (grant_en),
        .grant    (req_ready),
        .grant_id (grant_id),
        .accept   (accept)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (drain_req)          state_nxt = ST_DRAIN;
            ST_DRAIN: if (inflight_q == '0)   state_nxt = ST_DONE;
            ST_DONE:  if (!drain_req)         state_nxt = ST_RUN;
            default:                          state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        grant_en   = (state == ST_RUN) && !drain_req;
        drain_done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpm_a <= '0;
            fpm_b <= '0;
        end else if (accept) begin
            fpm_a <= req_a[32*int'(grant_id) +: 32];
            fpm_b <= req_b[32*int'(grant_id) +: 32];
        end
    end

    assign new_tag = '{valid: accept, id: TAG_IDW'(grant_id)};

    // Stage 0 loads with fpm_a/fpm_b, so stage LATENCY lines up with fpm_sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= new_tag;
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign rsp_valid     = tag_pipe[LATENCY].valid;
    assign rsp_id        = tag_pipe[LATENCY].id[IDW-1:0];
    assign rsp_data      = fpm_sum;
    assign tag_id_unused = ^tag_pipe[LATENCY].id;

    // An op leaves the count on the edge that presents it as rsp_valid, so the
    // count tracks stages 0..LATENCY-1 and tops out at LATENCY.
    assign retire = tag_pipe[LATENCY-1].valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else if (accept && !retire) begin
            inflight_q <= inflight_q + CW'(1);
        end else if (!accept && retire) begin
            inflight_q <= inflight_q - CW'(1);
        end
    end

    assign inflight = inflight_q;
    assign busy     = (inflight_q != '0);

endmodule
